// File: rtl/decodificador_pwm.sv
// Decodes a 4-level PWM width code (0..3) from period/high-time measurements, with tolerance and timeout handling.
// Latency: report outputs update 1 cycle after the synchronized edge (3-4 cycles after the pwm pin edge).
// Backpressure: none; valido/erro are single-cycle pulses that must be sampled when asserted.
module decodificador_pwm #(
    parameter int conf_periodo  = 1250,
    parameter int valor_inicial = 50,
    parameter int tol_largura   = 10,
    parameter int tol_periodo   = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pwm,
    output logic [1:0]  largura,
    output logic        valido,
    output logic        erro,
    output logic        travado,
    output logic [31:0] alto_medido,
    output logic [31:0] periodo_medido
);

    typedef enum logic [1:0] {ESPERA, MEDE_ALTO, MEDE_BAIXO} estado_t;

    // Without a rising edge for two nominal periods the line is treated as constant.
    localparam logic [31:0] LIMITE = 32'(2 * conf_periodo);

    estado_t     estado;
    logic        sinc1, s, s_ant;
    logic        subida, descida;
    logic [31:0] cnt_per, cnt_alto;
    logic        expirou;
    logic        per_ok, k_ok;
    logic [1:0]  k_val;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1 <= 1'b0;
            s     <= 1'b0;
            s_ant <= 1'b0;
        end else begin
            sinc1 <= pwm;
            s     <= sinc1;
            s_ant <= s;
        end
    end

    assign subida  = s & ~s_ant;
    assign descida = ~s & s_ant;

    // Classify the running counters; only consulted on the closing rising edge.
    always_comb begin
        per_ok = ({2'b00, cnt_per} + 34'(tol_periodo) >= 34'(conf_periodo)) &&
                 ({2'b00, cnt_per} <= 34'(conf_periodo + tol_periodo));
        k_ok   = 1'b0;
        k_val  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (({2'b00, cnt_alto} + 34'(tol_largura) >= 34'(k * valor_inicial)) &&
                ({2'b00, cnt_alto} <= 34'(k * valor_inicial + tol_largura))) begin
                k_ok  = 1'b1;
                k_val = 2'(k);
            end
        end
    end

    // Measurement FSM, counters and registered report outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado         <= ESPERA;
            cnt_per        <= 32'd0;
            cnt_alto       <= 32'd0;
            expirou        <= 1'b0;
            largura        <= 2'd0;
            valido         <= 1'b0;
            erro           <= 1'b0;
            travado        <= 1'b0;
            alto_medido    <= 32'd0;
            periodo_medido <= 32'd0;
        end else begin
            valido <= 1'b0;
            erro   <= 1'b0;
            if (subida) begin
                // A rising edge always wins, even on the timeout cycle.
                cnt_per  <= 32'd1;
                cnt_alto <= 32'd1;
                expirou  <= 1'b0;
                estado   <= MEDE_ALTO;
                if (estado == MEDE_BAIXO) begin
                    if (per_ok && k_ok) begin
                        largura        <= k_val;
                        alto_medido    <= cnt_alto;
                        periodo_medido <= cnt_per;
                        valido         <= 1'b1;
                        travado        <= 1'b1;
                    end else begin
                        erro    <= 1'b1;
                        travado <= 1'b0;
                    end
                end
            end else if (!expirou && cnt_per == LIMITE) begin
                // Single report for a flat line; the counter then parks here.
                expirou <= 1'b1;
                estado  <= ESPERA;
                if (s) begin
                    erro    <= 1'b1;
                    travado <= 1'b0;
                end else begin
                    largura        <= 2'd0;
                    alto_medido    <= 32'd0;
                    periodo_medido <= 32'd0;
                    valido         <= 1'b1;
                    travado        <= 1'b1;
                end
            end else begin
                if (!expirou) cnt_per <= sat_inc(cnt_per);
                if (s) cnt_alto <= sat_inc(cnt_alto);
                if (estado == MEDE_ALTO && descida) estado <= MEDE_BAIXO;
            end
        end
    end

endmodule
